xalu: RTL and testbench
=======================

XALU -- requirements
Module: xalu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Start, input, 1 bit: an operation is issued this cycle.
REQ-004 SHALL have port Op, input, 3 bits: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; values 6-7 are ignored.
REQ-005 SHALL have port A, input, 32 bits: rs operand (dividend, multiplicand, or MTHI/MTLO data).
REQ-006 SHALL have port B, input, 32 bits: rt operand (divisor or multiplier).
REQ-007 SHALL have port ExceptionFlush, input, 1 bit: when high, the Start in the same cycle is discarded.
REQ-008 SHALL have port Busy, output, 1 bit: a multi-cycle operation is in flight; consumed by the hazard unit to stall the HI/LO instruction family.
REQ-009 SHALL have ports HI and LO, output, 32 bits each: the architectural HI/LO registers, driven directly from flops.

Function
REQ-010 SHALL accept an issue when Start=1, ExceptionFlush=0, Busy=0 and Op<=5; all other Start cycles SHALL be ignored with no state change.
REQ-011 SHALL implement states IDLE, MUL_RUN, DIV_RUN and DIV_FIX, plus a 6-bit iteration counter.
REQ-012 SHALL handle MTHI/MTLO with no state change: HI (resp. LO) <= A at the issue edge, Busy stays 0, and the new value is visible the next cycle.
REQ-013 SHALL handle MULT/MULTU as follows:
- IDLE->MUL_RUN at the issue edge; operands are latched at that edge.
- Busy=1 for exactly 4 cycles.
- At the 4th edge, {HI,LO} <= 64-bit product (signed for MULT, unsigned for MULTU), and the state returns to IDLE.
REQ-014 SHALL handle DIV/DIVU as follows:
- IDLE->DIV_RUN at the issue edge, latching |A|, |B| and the sign bits (for DIVU, magnitudes equal the raw operands).
- DIV_RUN runs 32 restoring radix-2 iterations, one per cycle, counter 0..31.
- DIV_RUN->DIV_FIX after iteration 31.
- DIV_FIX applies signs and returns to IDLE.
- Busy=1 for exactly 33 cycles; HI/LO update at the DIV_FIX exit edge.
REQ-015 SHALL apply DIV sign rules: quotient negated iff sign(A)!=sign(B); remainder takes the sign of A; LO=quotient, HI=remainder.
REQ-016 SHALL return, for DIV 0x80000000 / 0xFFFFFFFF, LO=0x80000000 and HI=0x00000000, with no trap.
REQ-017 SHALL leave HI/LO unchanged on divide by zero (B=0); latency is still 33 cycles.
REQ-018 SHALL keep HI/LO stable while Busy=1; intermediate values SHALL be held only in internal registers.
REQ-019 SHALL drive Busy from a register: Busy=1 exactly in the cycles where the state is not IDLE.
REQ-020 SHALL let a new issue be accepted in the same cycle Busy returns to 0 (back-to-back operation, zero bubble).
REQ-021 SHALL NOT abort an in-flight operation when ExceptionFlush is asserted; the flush gates only new issues.

Reset
REQ-022 SHALL, on reset=1 at any time and regardless of clk, force: state=IDLE, counter=0, Busy=0, HI=0, LO=0, all internal datapath registers=0.
REQ-023 SHALL discard any operation in progress when reset is asserted mid-operation, with HI/LO=0 after reset.
REQ-024 SHALL accept an issue on the first rising edge after reset deasserts.

Verification
REQ-025 SHALL be covered by a MULT scenario: MULT A=0xFFFFFFFF, B=0x00000002 -> Busy high for 4 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-026 SHALL be covered by a DIV scenario: DIV A=0xFFFFFFF9 (-7), B=2 -> Busy high for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
REQ-027 SHALL be covered by a boundary scenario:
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU with B=0 after MTHI 0x12345678 -> HI stays 0x12345678 after 33 cycles.
REQ-028 SHALL be covered by a hazard scenario:
- Start+DIV with ExceptionFlush=1 -> Busy stays 0, HI/LO unchanged.
- Start+MTLO while Busy=1 -> ignored.
- MTLO issued in the cycle Busy falls -> accepted.
REQ-029 SHALL be covered by a reset scenario: reset pulsed at cycle 10 of a DIV -> Busy=0, HI=LO=0 immediately without a clock edge. MULT 3*5 issued on the next edge -> LO=15 after 4 cycles.

Source files
------------

// File: rtl/xalu.sv
// HI/LO multiply-divide unit: 4-cycle multiply, 33-cycle restoring divide, and MTHI/MTLO.
// Busy comes straight from a flop and is high in every cycle the FSM is away from IDLE.
module xalu (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ExceptionFlush,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DIV_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [32:0] ma_q, ma_d, mb_q, mb_d;
  logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic        negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

  logic        issue;
  logic        a_neg, b_neg;
  logic [65:0] prod;
  logic [32:0] shifted, diff;

  // Handshake: an issue is taken only when Start is high, no flush, the unit is idle and Op is defined.
  assign issue   = Start && !ExceptionFlush && !busy_q && (Op <= OP_MTLO);
  assign a_neg   = (Op == OP_DIV) && A[31];
  assign b_neg   = (Op == OP_DIV) && B[31];
  assign prod    = $signed(ma_q) * $signed(mb_q);
  assign shifted = {rem_q, dvd_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          case (Op)
            OP_MULT, OP_MULTU: begin
              ma_d    = {(Op == OP_MULT) && A[31], A};
              mb_d    = {(Op == OP_MULT) && B[31], B};
              cnt_d   = 6'd0;
              state_d = MUL_RUN;
            end
            OP_DIV, OP_DIVU: begin
              dvd_d   = a_neg ? -A : A;
              dvs_d   = b_neg ? -B : B;
              rem_d   = 32'd0;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              dz_d    = (B == 32'd0);
              cnt_d   = 6'd0;
              state_d = DIV_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      MUL_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd3) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          cnt_d   = 6'd0;
          state_d = IDLE;
        end
      end
      DIV_RUN: begin
        // Restoring step: keep the trial subtraction only when it did not borrow.
        rem_d = diff[32] ? shifted[31:0] : diff[31:0];
        dvd_d = {dvd_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          cnt_d   = 6'd0;
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        if (!dz_q) begin
          lo_d = negq_q ? -dvd_q : dvd_q;
          hi_d = negr_q ? -rem_q : rem_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      ma_q    <= 33'd0;
      mb_q    <= 33'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
    end
  end

  assign Busy        = busy_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_xalu.sv
// Bench for xalu: reference model computes {HI,LO} per operation, results queued at issue
// and compared when Busy drops; also covers flush, busy-ignore, zero-bubble issue and reset.
module tb_xalu;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        ExceptionFlush;
  logic        Busy;
  logic [31:0] HI, LO;
  logic [1:0]  dbg_state_o;

  logic [63:0] exp_q[$];
  logic [63:0] cur_m;
  int          n_checks;
  int          n_pass;

  xalu dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .ExceptionFlush(ExceptionFlush), .Busy(Busy), .HI(HI), .LO(LO),
    .dbg_state_o(dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    logic [63:0] res;
    res = cur;
    case (op)
      3'd0: begin sa = longint'($signed(a)); sb = longint'($signed(b)); res = sa * sb; end
      3'd1: begin sa = longint'(a); sb = longint'(b); res = sa * sb; end
      3'd2: if (b != 0) begin
              sa = longint'($signed(a)); sb = longint'($signed(b));
              q = sa / sb; r = sa % sb;
              res = {r[31:0], q[31:0]};
            end
      3'd3: if (b != 0) begin
              sa = longint'(a); sb = longint'(b);
              q = sa / sb; r = sa % sb;
              res = {r[31:0], q[31:0]};
            end
      3'd4: res = {a, cur[31:0]};
      3'd5: res = {cur[63:32], a};
      default: res = cur;
    endcase
    return res;
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op <= 3'd1) return 4;
    if (op <= 3'd3) return 33;
    return 0;
  endfunction

  // Called in the low clock phase; the following rising edge is the issue edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int nbusy;
    int stable;
    int lat;
    logic [63:0] got;
    lat = latency(op);
    exp_q.push_back(model(op, a, b, cur_m));
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0;
    nbusy = 0;
    stable = 1;
    for (int i = 0; i < 40 && Busy; i++) begin
      nbusy++;
      if ({HI, LO} !== cur_m) stable = 0;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 64'(nbusy), 64'(lat));
    if (lat > 0) check({tag, "_hilo_stable"}, 64'(stable), 64'd1);
    got = exp_q.pop_front();
    check({tag, "_hilo"}, {HI, LO}, got);
    cur_m = got;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    cur_m = 64'd0;
    reset = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0; ExceptionFlush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'd0);
    reset = 1'b0;

    // Issue on the first edge after reset release.
    run_op("mthi", 3'd4, 32'h1111_1111, 32'd0);
    run_op("mtlo", 3'd5, 32'h2222_2222, 32'd0);
    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    check("mult_ref", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    check("multu_ref", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_ref", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", 3'd3, 32'd7, 32'd2);
    check("divu_ref", {HI, LO}, 64'h0000_0001_0000_0003);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_ref", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op("mthi2", 3'd4, 32'h1234_5678, 32'd0);
    run_op("divu_z", 3'd3, 32'd99, 32'd0);
    check("divu_z_hi", 64'(HI), 64'h1234_5678);
    run_op("op6", 3'd6, 32'hAAAA_AAAA, 32'd1);
    run_op("div_neg", 3'd2, 32'd100, 32'hFFFF_FFF9);

    // Flushed issue must be dropped.
    Start = 1'b1; Op = 3'd2; A = 32'd50; B = 32'd5; ExceptionFlush = 1'b1;
    @(negedge clk);
    Start = 1'b0; ExceptionFlush = 1'b0;
    check("flush_busy", 64'(Busy), 64'd0);
    check("flush_hilo", {HI, LO}, cur_m);

    // MTLO during a divide is ignored; MTLO in the cycle Busy falls is taken.
    exp_q.push_back(model(3'd3, 32'd100, 32'd7, cur_m));
    Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    Start = 1'b1; Op = 3'd5; A = 32'h0000_DEAD;
    @(negedge clk);
    Start = 1'b0;
    for (int i = 0; i < 40 && Busy; i++) @(negedge clk);
    cur_m = exp_q.pop_front();
    check("busy_ign_hilo", {HI, LO}, cur_m);
    exp_q.push_back(model(3'd5, 32'h0000_BEEF, 32'd0, cur_m));
    Start = 1'b1; Op = 3'd5; A = 32'h0000_BEEF;
    @(negedge clk);
    Start = 1'b0;
    cur_m = exp_q.pop_front();
    check("b2b_mtlo", {HI, LO}, cur_m);
    check("b2b_mtlo_ref", {HI, LO}, 64'h0000_0002_0000_BEEF);

    // Random back-to-back traffic.
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 6));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) rb = 32'($urandom_range(1, 20));
      run_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    // Asynchronous reset in the middle of a divide.
    Start = 1'b1; Op = 3'd2; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 64'(Busy), 64'd0);
    check("arst_hilo", {HI, LO}, 64'd0);
    check("arst_state", 64'(dbg_state_o), 64'd0);
    #1 reset = 1'b0;
    cur_m = 64'd0;
    run_op("post_rst_mult", 3'd0, 32'd3, 32'd5);
    check("post_rst_ref", {HI, LO}, 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
